// File: rtl/char_fetch_scheduler.sv
// Shares the single-port character RAM between row prefetch (priority, in blanking) and the CPU, and feeds the glyph stage.
// Prefetch: first address 1 cycle after trigger, back in IDLE after WIDTH_CHARS+2; CPU waits (no grant) while a prefetch runs.
module char_fetch_scheduler #(
    parameter int WIDTH_CHARS  = 16,
    parameter int HEIGHT_CHARS = 12,
    parameter int CHARW        = 8,
    parameter int CHARH        = 8,
    parameter int RS           = 1,
    parameter int ADDR_W       = 8,
    parameter int CODE_W       = 8
) (
    input  logic                     vga_clk,
    input  logic                     reset_n,
    input  logic                     datasource,
    input  logic                     VS,
    input  logic                     cpu_req,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [CODE_W-1:0]        cpu_wdata,
    output logic                     cpu_gnt,
    output logic [CODE_W-1:0]        cpu_rdata,
    output logic                     cpu_rvalid,
    output logic [ADDR_W-1:0]        ram_addr,
    output logic                     ram_we,
    output logic [CODE_W-1:0]        ram_wdata,
    input  logic [CODE_W-1:0]        ram_rdata,
    output logic                     pix_valid,
    output logic [CODE_W-1:0]        char_code,
    output logic [$clog2(CHARW)-1:0] glyph_x,
    output logic [$clog2(CHARH)-1:0] glyph_y,
    output logic                     fetch_overrun
);
    localparam int CELLW = CHARW * RS;
    localparam int CELLH = CHARH * RS;
    localparam int LINES = HEIGHT_CHARS * CELLH;
    localparam int LYW   = $clog2(LINES);
    localparam int PXW   = $clog2(WIDTH_CHARS * CELLW);
    localparam int COLW  = $clog2(WIDTH_CHARS);
    localparam int GXW   = $clog2(CHARW);
    localparam int GYW   = $clog2(CHARH);

    typedef enum logic [1:0] {IDLE, PREFETCH, DRAIN} state_t;

    state_t             state, state_nxt;
    logic               vs_q, ds_q;
    logic               vs_fall, ds_fall, ds_trig, trig;
    logic [LYW-1:0]     ly, ly_inc;
    logic [COLW-1:0]    col, fill_col, pcol;
    logic               fill_vld, rd_pend;
    logic [PXW-1:0]     px;
    logic [ADDR_W-1:0]  base;
    logic [CODE_W-1:0]  linebuf [WIDTH_CHARS];

    assign vs_fall = vs_q & ~VS;
    assign ds_fall = ds_q & ~datasource;
    assign ly_inc  = (ly == LYW'(LINES - 1)) ? ly : ly + 1'b1;
    // A saturated ly never advances, so it can never re-trigger a row.
    assign ds_trig = ds_fall && (ly != LYW'(LINES - 1)) && ((int'(ly_inc) % CELLH) == 0);
    assign trig    = vs_fall | ds_trig;
    assign base    = vs_fall ? '0 : ADDR_W'((int'(ly_inc) / CELLH) * WIDTH_CHARS);
    assign pcol    = COLW'(int'(px) / CELLW);
    assign cpu_rdata = cpu_rvalid ? ram_rdata : '0;

    always_comb begin
        state_nxt = state;
        cpu_gnt   = 1'b0;
        case (state)
            IDLE: begin
                if (trig)
                    state_nxt = PREFETCH;
                else if (cpu_req && reset_n)
                    cpu_gnt = 1'b1;
            end
            PREFETCH: if (col == COLW'(WIDTH_CHARS - 1)) state_nxt = DRAIN;
            DRAIN:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            vs_q          <= 1'b1;
            ds_q          <= 1'b0;
            ly            <= '0;
            col           <= '0;
            ram_addr      <= '0;
            ram_we        <= 1'b0;
            ram_wdata     <= '0;
            fill_vld      <= 1'b0;
            fill_col      <= '0;
            rd_pend       <= 1'b0;
            cpu_rvalid    <= 1'b0;
            fetch_overrun <= 1'b0;
            px            <= '0;
            pix_valid     <= 1'b0;
            char_code     <= '0;
            glyph_x       <= '0;
            glyph_y       <= '0;
        end else begin
            state    <= state_nxt;
            vs_q     <= VS;
            ds_q     <= datasource;
            fill_vld <= (state == PREFETCH);
            fill_col <= col;
            ram_we   <= 1'b0;

            if (vs_fall)
                ly <= '0;
            else if (ds_fall)
                ly <= ly_inc;

            if (state == IDLE && trig) begin
                col      <= '0;
                ram_addr <= base;
            end else if (state == PREFETCH && col != COLW'(WIDTH_CHARS - 1)) begin
                col      <= col + 1'b1;
                ram_addr <= ram_addr + 1'b1;
            end else if (cpu_gnt) begin
                ram_addr  <= cpu_addr;
                ram_we    <= cpu_we;
                ram_wdata <= cpu_wdata;
            end

            // Read data is on ram_rdata the cycle after the address is presented.
            rd_pend    <= cpu_gnt & ~cpu_we;
            cpu_rvalid <= rd_pend;

            if (state != IDLE && (trig || datasource))
                fetch_overrun <= 1'b1;

            px        <= datasource ? px + 1'b1 : '0;
            pix_valid <= datasource;
            if (datasource) begin
                char_code <= linebuf[pcol];
                glyph_x   <= GXW'((int'(px) % CELLW) / RS);
                glyph_y   <= GYW'((int'(ly) % CELLH) / RS);
            end else begin
                char_code <= '0;
                glyph_x   <= '0;
                glyph_y   <= '0;
            end
        end
    end

    always_ff @(posedge vga_clk) begin
        if (fill_vld)
            linebuf[fill_col] <= ram_rdata;
    end
endmodule

// File: tb/tb_char_fetch_scheduler.sv
// Directed bench for char_fetch_scheduler with a behavioural 1-cycle synchronous RAM.
module tb_char_fetch_scheduler;
    logic       vga_clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       datasource = 1'b0;
    logic       VS = 1'b1;
    logic       cpu_req = 1'b0;
    logic       cpu_we = 1'b0;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_wdata = '0;
    logic       cpu_gnt, cpu_rvalid, ram_we, pix_valid, fetch_overrun;
    logic [7:0] cpu_rdata, ram_addr, ram_wdata, ram_rdata, char_code;
    logic [2:0] glyph_x, glyph_y;

    logic [7:0] mem [256];
    bit         wr_seen [256];
    int         checks = 0;
    int         failures = 0;
    int         ly_m = 0;

    char_fetch_scheduler dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .datasource(datasource), .VS(VS),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pix_valid(pix_valid), .char_code(char_code), .glyph_x(glyph_x), .glyph_y(glyph_y),
        .fetch_overrun(fetch_overrun)
    );

    always #5 vga_clk = ~vga_clk;

    // Unwritten locations read back their own address.
    always @(posedge vga_clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_wdata;
            wr_seen[ram_addr] <= 1'b1;
        end
        ram_rdata <= wr_seen[ram_addr] ? mem[ram_addr] : ram_addr;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic ds_pulse();
        datasource = 1'b1;
        cyc();
        datasource = 1'b0;
        cyc();
        if (ly_m < 95) begin
            ly_m++;
            if (ly_m % 8 == 0) repeat (20) cyc();
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++; if ({cpu_gnt, cpu_rvalid, ram_we, pix_valid, fetch_overrun} !== 5'b0) begin failures++; $display("FAIL reset_flags: got %b expected 00000", {cpu_gnt, cpu_rvalid, ram_we, pix_valid, fetch_overrun}); end
        checks++; if ({ram_addr, ram_wdata, cpu_rdata, char_code, glyph_x, glyph_y} !== 38'b0) begin failures++; $display("FAIL reset_buses: addr=%h wdata=%h rdata=%h code=%h gx=%0d gy=%0d expected all 0", ram_addr, ram_wdata, cpu_rdata, char_code, glyph_x, glyph_y); end
        reset_n = 1'b1;
        repeat (3) cyc();
        checks++; if (ram_we !== 1'b0 || ram_addr !== 8'd0) begin failures++; $display("FAIL reset_idle: ram_we=%b ram_addr=%0d expected 0/0", ram_we, ram_addr); end
    endtask

    task automatic test_vs_fall();
        VS = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'd40; cpu_wdata = 8'h41;
        #1;
        checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL trig_beats_cpu: cpu_gnt=%b expected 0", cpu_gnt); end
        for (int k = 0; k < 16; k++) begin
            cyc();
            VS = 1'b1;
            #1;
            checks++; if (ram_addr !== 8'(k) || ram_we !== 1'b0 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL prefetch_row0[%0d]: addr=%0d we=%b gnt=%b expected addr=%0d we=0 gnt=0", k, ram_addr, ram_we, cpu_gnt, k); end
        end
        cyc(); #1;
        checks++; if (cpu_gnt !== 1'b0) begin failures++; $display("FAIL drain_no_gnt: cpu_gnt=%b expected 0", cpu_gnt); end
        cyc(); #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL gnt_first_idle: cpu_gnt=%b expected 1", cpu_gnt); end
        cyc();
        cpu_req = 1'b0; cpu_we = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 8'd40 || ram_wdata !== 8'h41) begin failures++; $display("FAIL cpu_write_issue: we=%b addr=%0d wdata=%h expected 1/40/41", ram_we, ram_addr, ram_wdata); end
        cyc(); #1;
        checks++; if (ram_we !== 1'b0 || cpu_gnt !== 1'b0) begin failures++; $display("FAIL cpu_write_once: we=%b gnt=%b expected 0/0", ram_we, cpu_gnt); end
        checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("FAIL no_overrun_vs: fetch_overrun=%b expected 0", fetch_overrun); end
        ly_m = 0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd40;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL read_gnt_same_cycle: cpu_gnt=%b expected 1", cpu_gnt); end
        cyc();
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_rvalid !== 1'b0 || ram_addr !== 8'd40 || ram_we !== 1'b0) begin failures++; $display("FAIL read_issue: rvalid=%b addr=%0d we=%b expected 0/40/0", cpu_rvalid, ram_addr, ram_we); end
        cyc(); #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'h41) begin failures++; $display("FAIL read_data: rvalid=%b rdata=%h expected 1/41", cpu_rvalid, cpu_rdata); end
        cyc(); #1;
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL read_pulse: rvalid=%b expected 0", cpu_rvalid); end
    endtask

    task automatic test_back_to_back();
        cpu_req = 1'b1; cpu_addr = 8'd5;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt0: cpu_gnt=%b expected 1", cpu_gnt); end
        cyc();
        cpu_addr = 8'd6;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL b2b_gnt1: cpu_gnt=%b expected 1", cpu_gnt); end
        cyc();
        cpu_req = 1'b0;
        #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'd5) begin failures++; $display("FAIL b2b_data0: rvalid=%b rdata=%0d expected 1/5", cpu_rvalid, cpu_rdata); end
        cyc(); #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'd6) begin failures++; $display("FAIL b2b_data1: rvalid=%b rdata=%0d expected 1/6", cpu_rvalid, cpu_rdata); end
        cyc(); #1;
        checks++; if (cpu_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_end: rvalid=%b expected 0", cpu_rvalid); end
    endtask

    task automatic test_row_advance();
        repeat (7) ds_pulse();
        datasource = 1'b1;
        cyc();
        datasource = 1'b0;
        ly_m = 8;
        for (int k = 0; k < 16; k++) begin
            cyc(); #1;
            checks++; if (ram_addr !== 8'(16 + k) || ram_we !== 1'b0) begin failures++; $display("FAIL prefetch_row1[%0d]: addr=%0d we=%b expected %0d/0", k, ram_addr, ram_we, 16 + k); end
        end
        repeat (4) cyc();
        datasource = 1'b1;
        for (int p = 0; p < 128; p++) begin
            cyc();
            if (p == 127) datasource = 1'b0;
            #1;
            checks++; if (pix_valid !== 1'b1 || char_code !== 8'(16 + p / 8) || glyph_x !== 3'(p % 8) || glyph_y !== 3'd0) begin failures++; $display("FAIL line8_pix[%0d]: v=%b code=%h gx=%0d gy=%0d expected 1/%h/%0d/0", p, pix_valid, char_code, glyph_x, glyph_y, 16 + p / 8, p % 8); end
        end
        cyc(); #1;
        checks++; if (pix_valid !== 1'b0 || char_code !== 8'h00) begin failures++; $display("FAIL line8_end: v=%b code=%h expected 0/00", pix_valid, char_code); end
        ly_m = 9;
        datasource = 1'b1;
        cyc();
        datasource = 1'b0;
        #1;
        checks++; if (pix_valid !== 1'b1 || char_code !== 8'h10 || glyph_x !== 3'd0 || glyph_y !== 3'd1) begin failures++; $display("FAIL line9_pix: v=%b code=%h gx=%0d gy=%0d expected 1/10/0/1", pix_valid, char_code, glyph_x, glyph_y); end
        cyc();
        ly_m = 10;
    endtask

    task automatic test_ly_saturate();
        while (ly_m < 95) ds_pulse();
        datasource = 1'b1;
        cyc();
        datasource = 1'b0;
        #1;
        checks++; if (glyph_y !== 3'd7 || char_code !== 8'hB0) begin failures++; $display("FAIL last_line: gy=%0d code=%h expected 7/b0", glyph_y, char_code); end
        cyc();
        repeat (3) ds_pulse();
        repeat (20) cyc();
        checks++; if (ram_addr !== 8'd191 || ram_we !== 1'b0) begin failures++; $display("FAIL ly_saturate_no_fetch: addr=%0d we=%b expected 191/0", ram_addr, ram_we); end
        datasource = 1'b1;
        cyc();
        datasource = 1'b0;
        #1;
        checks++; if (glyph_y !== 3'd7 || char_code !== 8'hB0) begin failures++; $display("FAIL ly_saturate_hold: gy=%0d code=%h expected 7/b0", glyph_y, char_code); end
        cyc();
        checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("FAIL no_overrun_rows: fetch_overrun=%b expected 0", fetch_overrun); end
    endtask

    task automatic test_overrun();
        VS = 1'b0;
        cyc();
        VS = 1'b1;
        repeat (3) cyc();
        datasource = 1'b1;
        #1;
        checks++; if (fetch_overrun !== 1'b0) begin failures++; $display("FAIL overrun_before: fetch_overrun=%b expected 0", fetch_overrun); end
        cyc();
        datasource = 1'b0;
        #1;
        checks++; if (fetch_overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: fetch_overrun=%b expected 1", fetch_overrun); end
        repeat (25) cyc();
        checks++; if (fetch_overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky: fetch_overrun=%b expected 1", fetch_overrun); end
    endtask

    task automatic test_reset_mid_prefetch();
        VS = 1'b0;
        cyc();
        VS = 1'b1;
        repeat (3) cyc();
        checks++; if (ram_addr !== 8'd3) begin failures++; $display("FAIL mid_prefetch: ram_addr=%0d expected 3", ram_addr); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({cpu_gnt, cpu_rvalid, ram_we, pix_valid, fetch_overrun} !== 5'b0 || ram_addr !== 8'd0) begin failures++; $display("FAIL async_reset: flags=%b addr=%0d expected 00000/0", {cpu_gnt, cpu_rvalid, ram_we, pix_valid, fetch_overrun}, ram_addr); end
        cyc(); cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        checks++; if (ram_we !== 1'b0 || ram_addr !== 8'd0) begin failures++; $display("FAIL post_reset_quiet: we=%b addr=%0d expected 0/0", ram_we, ram_addr); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'd7;
        #1;
        checks++; if (cpu_gnt !== 1'b1) begin failures++; $display("FAIL post_reset_idle_gnt: cpu_gnt=%b expected 1", cpu_gnt); end
        cyc();
        cpu_req = 1'b0;
        cyc(); #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 8'd7) begin failures++; $display("FAIL post_reset_read: rvalid=%b rdata=%0d expected 1/7", cpu_rvalid, cpu_rdata); end
        cyc();
    endtask

    task automatic test_vs_low_at_reset();
        reset_n = 1'b0;
        VS = 1'b0;
        cyc(); cyc();
        reset_n = 1'b1;
        cyc(); cyc(); #1;
        checks++; if (ram_addr !== 8'd1 || ram_we !== 1'b0) begin failures++; $display("FAIL vs_low_release: addr=%0d we=%b expected 1/0", ram_addr, ram_we); end
        VS = 1'b1;
        repeat (20) cyc();
    endtask

    initial begin
        test_reset();
        cyc();
        test_vs_fall();
        cyc();
        test_cpu_read();
        cyc();
        test_back_to_back();
        cyc();
        test_row_advance();
        test_ly_saturate();
        test_overrun();
        test_reset_mid_prefetch();
        test_vs_low_at_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
